// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// bounce direction and the pattern reload helper.
package led_seq_pkg;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BIN    = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Reload value for a mode: a single dark bit at bit0, or all dark for the
  // binary counter (bin restarts at zero, and pat = ~bin).
  // Returned 32 bits wide; callers keep the low 'width' bits.
  function automatic logic [31:0] init_pat(input logic [1:0] mode, input int width);
    logic [31:0] ones;
    if (width >= 32) ones = 32'hFFFF_FFFF;
    else             ones = (32'd1 << width) - 32'd1;
    if (mode == MODE_BIN) return ones;
    return ones & ~32'd1;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Enable-gated up-counting prescaler. Counts 0..div and wraps, producing a
// one-cycle tick on the wrap. A synchronous clear restarts the period and
// swallows any tick in that cycle.
module led_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = en & ~clr & (cnt == div);

  // Counter: clear wins, otherwise advance while enabled. If div drops
  // below cnt the counter runs on to all-ones and wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == div) cnt <= '0;
      else            cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: four patterns stepped by a prescaler, active-low
// LED drive, live prescaler value on dbg_cnt.
// Optional brightness PWM is built when LED_PWM_EN is defined; otherwise
// led = pat and bright is accepted but unused.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int CNT_W = 24,
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] bright,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [LED_W-1:0] PAT_RST = LED_W'(init_pat(MODE_ROL, LED_W));

  logic [1:0]       mode_q;
  logic             reload;
  logic             tick;
  logic [LED_W-1:0] pat, pat_nxt;
  logic [LED_W-1:0] bin, bin_nxt, bin_inc;
  logic [LED_W-1:0] pat_rol, pat_ror;
  logic [LED_W-1:0] init_val;
  dir_t             dir, dir_nxt;

  assign reload   = (mode != mode_q);
  assign init_val = LED_W'(init_pat(mode, LED_W));
  assign bin_inc  = bin + LED_W'(1);
  assign pat_rol  = {pat[LED_W-2:0], pat[LED_W-1]};
  assign pat_ror  = {pat[0], pat[LED_W-1:1]};

  led_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (reload),
    .div  (div),
    .cnt  (dbg_cnt),
    .tick (tick)
  );

  // Next pattern: a mode change reloads and discards a coincident tick.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    bin_nxt = bin;
    if (reload) begin
      pat_nxt = init_val;
      dir_nxt = DIR_LEFT;
      bin_nxt = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_ROL: pat_nxt = pat_rol;
        MODE_ROR: pat_nxt = pat_ror;
        MODE_BOUNCE: begin
          // Turn around on arrival at an end so the end bit dwells once.
          if (dir == DIR_LEFT) begin
            pat_nxt = pat_rol;
            if (!pat_rol[LED_W-1]) dir_nxt = DIR_RIGHT;
          end else begin
            pat_nxt = pat_ror;
            if (!pat_ror[0]) dir_nxt = DIR_LEFT;
          end
        end
        MODE_BIN: begin
          bin_nxt = bin_inc;
          pat_nxt = ~bin_inc;
        end
        default: ;
      endcase
    end
  end

  // Pattern state, mode tracking and the registered step pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= MODE_ROL;
      step   <= 1'b0;
      pat    <= PAT_RST;
      dir    <= DIR_LEFT;
      bin    <= '0;
    end else begin
      mode_q <= mode;
      step   <= tick;
      pat    <= pat_nxt;
      dir    <= dir_nxt;
      bin    <= bin_nxt;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm, pwm_nxt;
  logic             dark_q;

  assign pwm_nxt = pwm + PWM_W'(1);

  // Free-running PWM; the dark mask is registered against the next pwm
  // value so it lines up with pwm and leaves no input-to-led path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm    <= '0;
      dark_q <= 1'b0;
    end else begin
      pwm    <= pwm_nxt;
      dark_q <= (pwm_nxt >= bright);
    end
  end

  assign led = pat | {LED_W{dark_q}};
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign led = pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer (LED_W=8, CNT_W=24).
// With LED_PWM_EN defined only the reset and brightness scenarios run.
module tb_led_sequencer;

  localparam int LED_W = 8;
  localparam int CNT_W = 24;
  localparam int PWM_W = 4;

  logic             clk    = 1'b0;
  logic             rstn   = 1'b0;
  logic             en     = 1'b0;
  logic [CNT_W-1:0] div    = '0;
  logic [1:0]       mode   = 2'd0;
  logic [PWM_W-1:0] bright = '0;
  logic [LED_W-1:0] led;
  logic             step;
  logic [CNT_W-1:0] dbg_cnt;

  int errors = 0;
  int checks = 0;

  // led value with the single dark bit at position p
  logic [7:0] dark [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  led_sequencer #(.LED_W(LED_W), .CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .div     (div),
    .mode    (mode),
    .bright  (bright),
    .led     (led),
    .step    (step),
    .dbg_cnt (dbg_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; div = 24'd3; mode = 2'd0; bright = 4'd8;
    cyc(); cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL reset_led got %h want fe", led); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dbg_cnt); end
    rstn = 1'b1;
    cyc();
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL reset_hold_cnt got %0d want 0", dbg_cnt); end
  endtask

  task automatic test_rotate_left();
    en = 1'b1; div = 24'd3; mode = 2'd0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      checks++;
      if (led !== dark[(k/4)%8]) begin errors++; $display("FAIL rol_led k=%0d got %h want %h", k, led, dark[(k/4)%8]); end
      checks++;
      if (step !== (k%4 == 0)) begin errors++; $display("FAIL rol_step k=%0d got %b want %b", k, step, (k%4 == 0)); end
      checks++;
      if (dbg_cnt !== 24'(k%4)) begin errors++; $display("FAIL rol_cnt k=%0d got %0d want %0d", k, dbg_cnt, k%4); end
    end
  endtask

  task automatic test_rotate_right();
    mode = 2'd1; div = 24'd0;
    cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL ror_reload got %h want fe", led); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL ror_reload_step got %b want 0", step); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (led !== dark[8-i]) begin errors++; $display("FAIL ror_led i=%0d got %h want %h", i, led, dark[8-i]); end
      checks++;
      if (step !== 1'b1) begin errors++; $display("FAIL ror_step i=%0d got %b want 1", i, step); end
    end
  endtask

  task automatic test_bounce();
    int bpos [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    mode = 2'd2; div = 24'd0;
    cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL bounce_reload got %h want fe", led); end
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++;
      if (led !== dark[bpos[i]]) begin errors++; $display("FAIL bounce_led i=%0d got %h want %h", i, led, dark[bpos[i]]); end
      checks++;
      if (step !== 1'b1) begin errors++; $display("FAIL bounce_step i=%0d got %b want 1", i, step); end
    end
  endtask

  task automatic test_binary();
    mode = 2'd3; div = 24'd1;
    cyc();
    checks++; if (led !== 8'hFF) begin errors++; $display("FAIL bin_reload got %h want ff", led); end
    for (int j = 1; j <= 256; j++) begin
      cyc();
      checks++;
      if (step !== 1'b0) begin errors++; $display("FAIL bin_mid_step j=%0d got %b want 0", j, step); end
      cyc();
      checks++;
      if (led !== 8'(~j)) begin errors++; $display("FAIL bin_led j=%0d got %h want %h", j, led, 8'(~j)); end
      checks++;
      if (step !== 1'b1) begin errors++; $display("FAIL bin_step j=%0d got %b want 1", j, step); end
    end
  endtask

  task automatic test_pause();
    mode = 2'd0; div = 24'd3; en = 1'b1;
    cyc(); cyc(); cyc();
    checks++; if (dbg_cnt !== 24'd2) begin errors++; $display("FAIL pause_pre_cnt got %0d want 2", dbg_cnt); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (led !== 8'hFE) begin errors++; $display("FAIL pause_led i=%0d got %h want fe", i, led); end
      checks++; if (dbg_cnt !== 24'd2) begin errors++; $display("FAIL pause_cnt i=%0d got %0d want 2", i, dbg_cnt); end
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL pause_step i=%0d got %b want 0", i, step); end
    end
    en = 1'b1;
    cyc();
    checks++; if (dbg_cnt !== 24'd3) begin errors++; $display("FAIL resume_cnt got %0d want 3", dbg_cnt); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL resume_early_step got %b want 0", step); end
    cyc();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL resume_step got %b want 1", step); end
    checks++; if (led !== 8'hFD) begin errors++; $display("FAIL resume_led got %h want fd", led); end
    cyc();
    en = 1'b0; mode = 2'd1;
    cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL pause_reload_led got %h want fe", led); end
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL pause_reload_cnt got %0d want 0", dbg_cnt); end
    cyc();
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL pause_after_reload_cnt got %0d want 0", dbg_cnt); end
  endtask

  task automatic test_reload_on_tick();
    en = 1'b1; mode = 2'd0; div = 24'd3;
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (led !== 8'hFD) begin errors++; $display("FAIL tickreload_pre_led got %h want fd", led); end
    checks++; if (dbg_cnt !== 24'd3) begin errors++; $display("FAIL tickreload_pre_cnt got %0d want 3", dbg_cnt); end
    mode = 2'd2;
    cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL tickreload_led got %h want fe", led); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL tickreload_step got %b want 0", step); end
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL tickreload_cnt got %0d want 0", dbg_cnt); end
    cyc();
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL tickreload_after_led got %h want fe", led); end
    checks++; if (dbg_cnt !== 24'd1) begin errors++; $display("FAIL tickreload_after_cnt got %0d want 1", dbg_cnt); end
  endtask

  task automatic test_async_reset();
    mode = 2'd0; div = 24'd0;
    cyc();
    mode = 2'd2;
    cyc(); cyc(); cyc(); cyc();
    checks++; if (led !== 8'hF7) begin errors++; $display("FAIL areset_pre_led got %h want f7", led); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (led !== 8'hFE) begin errors++; $display("FAIL areset_led got %h want fe", led); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL areset_step got %b want 0", step); end
    checks++; if (dbg_cnt !== 24'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", dbg_cnt); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_bright_ignored();
    en = 1'b0; bright = 4'd0;
    cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++; if (led !== 8'hFE) begin errors++; $display("FAIL bright_ignored i=%0d got %h want fe", i, led); end
    end
  endtask

  task automatic test_pwm();
    int lit;
    en = 1'b0; mode = 2'd0; bright = 4'd8;
    cyc(); cyc();
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (led == 8'hFE) lit++;
      checks++;
      if (led !== 8'hFE && led !== 8'hFF) begin errors++; $display("FAIL pwm_value i=%0d got %h want fe or ff", i, led); end
    end
    checks++; if (lit != 8) begin errors++; $display("FAIL pwm_duty8 got %0d lit want 8", lit); end
    bright = 4'd0;
    cyc(); cyc();
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (led == 8'hFE) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL pwm_duty0 got %0d lit want 0", lit); end
  endtask

  initial begin
    test_reset();
`ifdef LED_PWM_EN
    test_pwm();
`else
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_binary();
    test_pause();
    test_reload_on_tick();
    test_async_reset();
    test_bright_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Parametrised LED pattern sequencer for board bring-up and status display. It is the next generation of the single-pattern LED chaser.
- Programmable step rate via a prescaler.
- Four selectable patterns, run/pause control, and configurable LED width.
- Outputs drive active-low LEDs directly; the live prescaler value is exported on a debug bus for probing on GPIO headers.

Parameters:
LED_W, 8, number of LEDs driven; legal range 2..32
CNT_W, 24, prescaler width in bits; also the width of dbg_cnt
PWM_W, 4, brightness resolution in bits; used only with LED_PWM_EN

Ports:
clk  input  1  system clock; all logic on rising edge
rstn  input  1  asynchronous, active-low reset; asserts immediately, released synchronously by the board reset logic
en  input  1  1 = run; 0 = pause (prescaler and pattern hold)
div  input  CNT_W  prescaler terminal value; one step every div+1 enabled cycles
mode  input  2  0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
bright  input  PWM_W  duty level; ignored unless LED_PWM_EN
led  output  LED_W  active-low LED drive (0 = lit)
step  output  1  one-cycle pulse, registered, high in the cycle the pattern updates
dbg_cnt  output  CNT_W  current prescaler value

Behaviour:
Reset (rstn low, asynchronous):
- cnt = 0, step = 0, dir = left, bin = 0, mode_q = 0.
- pat = all ones except bit0 = 0, so led = ~1, i.e. 8'hFE for LED_W=8.

Prescaler:
- When en = 1: cnt increments each cycle. When cnt == div, cnt wraps to 0 and tick = 1 for that cycle.
- When en = 0: cnt holds and tick = 0.
- div = 0 gives a tick on every enabled cycle.
- If div is lowered below the current cnt, cnt counts up to all-ones, wraps naturally to 0, then matches div.
- step is tick registered, so it lags tick by one cycle. The pattern updates on the same edge that step rises.

Pattern update (on step):
- mode 0: pat rotates left; MSB goes to bit0.
- mode 1: pat rotates right; bit0 goes to MSB.
- mode 2 (bounce): the dark bit moves one position in direction dir.
  - Reaching bit LED_W-1 sets dir = right.
  - Reaching bit0 sets dir = left.
  - The end bit stays lit for exactly one step period; there is no double-dwell.
- mode 3: bin increments modulo 2^LED_W; pat = ~bin.

Mode change:
- mode_q registers mode each cycle. When mode != mode_q, the next edge does all of the following:
  - pat reloads to ~1 (or ~0 for mode 3, which clears bin).
  - dir = left.
  - cnt = 0.
- A reload takes priority over a coincident step; that step is discarded.

Pause:
- With en = 0, led and dbg_cnt hold.
- A mode change during pause still reloads the pattern.

Latency and timing:
- Outputs are registered; there is no combinational path from inputs to led.
- Steady-state step period is div+1 enabled cycles.

Optional Feature:
LED_PWM_EN
- Defined:
  - A free-running PWM_W-bit counter pwm increments every cycle, regardless of en.
  - led = pat | {LED_W{pwm >= bright}}.
  - Lit LEDs are on for bright/2^PWM_W of each PWM cycle; bright = 0 means all LEDs dark.
  - The PWM counter resets to 0.
- Undefined:
  - led = pat.
  - bright is unused; the port remains present so top-level wiring is identical.

Decomposition:
Package led_seq_pkg holds:
- mode encodings MODE_ROL = 2'd0, MODE_ROR = 2'd1, MODE_BOUNCE = 2'd2, MODE_BIN = 2'd3.
- function init_pat(mode, LED_W) returning the reload value.

Sub-module led_prescaler contains cnt, div compare, tick, and en gating. It is reused later by other timed status blocks. Pattern logic stays in the top module.

Test Plan:
1. Reset then en=1, div=3, mode=0, LED_W=8 -> step every 4 cycles; led sequence FE, FD, FB, F7 ... 7F, FE; dbg_cnt cycles 0..3.
2. mode=1, div=0 -> step every cycle; led FE, 7F, BF, DF.
3. mode=2, div=0, 16 steps -> dark bit runs 0..7..0; positions 7 and 0 each appear once per sweep; no repeated value.
4. mode=3, div=1 -> led = ~0, ~1, ~2 ...; after 256 steps it wraps to FF.
5. en=0 mid-period with cnt=2 -> led and dbg_cnt frozen for 10 cycles; on en=1 the next step arrives after 2 cycles (cnt 2→3 then tick).
6. Switch mode 0→2 on a cycle that coincides with tick -> no step applied; led = FE, cnt = 0. Also assert rstn low mid-sequence -> led = FE and step = 0 immediately, asynchronously. With LED_PWM_EN and bright = 8 -> each lit LED low for 8 of every 16 cycles.
